// File: rtl/axi_interconnect_fifogen_ptr_ctrl_if.sv
// Handshake and pointer/status bundle between a FIFO side and its pointer controller.
// The slave modport is the controller's view; master is the user/synchroniser side.
interface axi_interconnect_fifogen_ptr_ctrl_if #(
  parameter int unsigned AW = 4
);
  logic          inc_req;
  logic          inc_ack;
  logic [AW-1:0] loc_addr;
  logic [AW:0]   loc_gray;
  logic [AW:0]   rmt_gray;
  logic [AW:0]   level;
  logic          full;
  logic          empty;
  logic          afull;
  logic          aempty;
  logic          ptr_err;

  modport master (
    output inc_req, rmt_gray,
    input  inc_ack, loc_addr, loc_gray, level, full, empty, afull, aempty, ptr_err
  );

  modport slave (
    input  inc_req, rmt_gray,
    output inc_ack, loc_addr, loc_gray, level, full, empty, afull, aempty, ptr_err
  );
endinterface

// File: rtl/axi_interconnect_fifogen_ptr_ctrl.sv
// One side of an async FIFO: local pointer, registered Gray publish, remote Gray
// decode pipeline, occupancy and conservative full/empty/almost flags.
module axi_interconnect_fifogen_ptr_ctrl #(
  parameter int unsigned AW        = 4,
  parameter int unsigned MODE      = 0,
  parameter int unsigned PIPE_LINE = 1,
  parameter int unsigned AFULL_TH  = (1 << AW) - 2,
  parameter int unsigned AEMPTY_TH = 1
) (
  input logic                              clk_sys,
  input logic                              rst,
  axi_interconnect_fifogen_ptr_ctrl_if.slave bus
);
  localparam int unsigned PW    = AW + 1;
  localparam int unsigned DEPTH = 1 << AW;
  localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);
  localparam logic [PW-1:0] AFULL_P  = PW'(AFULL_TH);
  localparam logic [PW-1:0] AEMPTY_P = PW'(AEMPTY_TH);

  logic [PW-1:0] loc_bin;
  logic [PW-1:0] loc_gray_q;
  logic [PW-1:0] level_q;
  logic          full_q;
  logic          empty_q;
  logic          afull_q;
  logic          aempty_q;
  logic          err_q;

  logic          inc_ack_c;
  logic [PW-1:0] loc_bin_nxt;
  logic [PW-1:0] loc_gray_nxt;
  logic [PW-1:0] rmt_bin_c;
  logic [PW-1:0] rmt_bin_dec;
  logic [PW-1:0] lvl_nxt;
  logic          err_nxt;
  logic          full_nxt;
  logic          empty_nxt;
  logic          afull_nxt;
  logic          aempty_nxt;

  // Gate on registered flags only; the reset cycle never acknowledges.
  always_comb begin
    inc_ack_c = 1'b0;
    if (!rst) begin
      inc_ack_c = bus.inc_req & ~((MODE == 0) ? full_q : empty_q);
    end
  end

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rmt_bin_c = '0;
    for (int i = 0; i < int'(PW); i++) begin
      rmt_bin_c[i] = ^(bus.rmt_gray >> i);
    end
  end

  generate
    if (PIPE_LINE == 0) begin : g_nopipe
      assign rmt_bin_dec = rmt_bin_c;
    end else begin : g_pipe
      logic [PW-1:0] stg [PIPE_LINE];

      always_ff @(posedge clk_sys) begin
        if (rst) begin
          for (int i = 0; i < int'(PIPE_LINE); i++) stg[i] <= '0;
        end else begin
          stg[0] <= rmt_bin_c;
          for (int i = 1; i < int'(PIPE_LINE); i++) stg[i] <= stg[i-1];
        end
      end

      assign rmt_bin_dec = stg[PIPE_LINE-1];
    end
  endgenerate

  // Level and every flag come from one next-level value so they never disagree.
  always_comb begin
    loc_bin_nxt  = loc_bin + PW'(inc_ack_c);
    loc_gray_nxt = loc_bin_nxt ^ (loc_bin_nxt >> 1);
    lvl_nxt      = (MODE == 0) ? (loc_bin_nxt - rmt_bin_dec) : (rmt_bin_dec - loc_bin_nxt);
    err_nxt      = err_q | (lvl_nxt > DEPTH_P);
    full_nxt     = (lvl_nxt == DEPTH_P) | ((MODE == 0) & err_nxt);
    empty_nxt    = (lvl_nxt == '0)      | ((MODE != 0) & err_nxt);
    afull_nxt    = (lvl_nxt >= AFULL_P);
    aempty_nxt   = (lvl_nxt <= AEMPTY_P);
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      loc_bin    <= '0;
      loc_gray_q <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      afull_q    <= 1'b0;
      aempty_q   <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      loc_bin    <= loc_bin_nxt;
      loc_gray_q <= loc_gray_nxt;
      level_q    <= lvl_nxt;
      full_q     <= full_nxt;
      empty_q    <= empty_nxt;
      afull_q    <= afull_nxt;
      aempty_q   <= aempty_nxt;
      err_q      <= err_nxt;
    end
  end

  assign bus.inc_ack  = inc_ack_c;
  assign bus.loc_addr = loc_bin[AW-1:0];
  assign bus.loc_gray = loc_gray_q;
  assign bus.level    = level_q;
  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.afull    = afull_q;
  assign bus.aempty   = aempty_q;
  assign bus.ptr_err  = err_q;

endmodule

// File: tb/tb_axi_interconnect_fifogen_ptr_ctrl.sv
// Three controller instances (write AW3/no pipe, read AW3/pipe2, write AW4/pipe1)
// checked every cycle against an integer pointer-count model plus directed checks.
module tb_axi_interconnect_fifogen_ptr_ctrl;
  localparam int N  = 3;
  localparam int HL = 64;

  logic clk_sys = 1'b0;
  logic rst;
  always #5 clk_sys = ~clk_sys;

  axi_interconnect_fifogen_ptr_ctrl_if #(.AW(3)) if0 ();
  axi_interconnect_fifogen_ptr_ctrl_if #(.AW(3)) if1 ();
  axi_interconnect_fifogen_ptr_ctrl_if #(.AW(4)) if2 ();

  axi_interconnect_fifogen_ptr_ctrl #(.AW(3), .MODE(0), .PIPE_LINE(0)) dut0 (
    .clk_sys(clk_sys), .rst(rst), .bus(if0));
  axi_interconnect_fifogen_ptr_ctrl #(.AW(3), .MODE(1), .PIPE_LINE(2)) dut1 (
    .clk_sys(clk_sys), .rst(rst), .bus(if1));
  axi_interconnect_fifogen_ptr_ctrl #(.AW(4), .MODE(0), .PIPE_LINE(1)) dut2 (
    .clk_sys(clk_sys), .rst(rst), .bus(if2));

  int c_aw [N];
  int c_mode [N];
  int c_pipe [N];
  int c_afth [N];
  int c_aeth [N];

  bit req [N];
  int rbin [N];

  int total = 0;
  int bad   = 0;

  int m_loc [N];
  int m_lvl [N];
  int m_full [N];
  int m_empty [N];
  int m_afull [N];
  int m_aempty [N];
  int m_err [N];
  int n_ack [N];
  int rh [N][HL];
  int ncyc;

  logic [31:0] o_ack [N];
  logic [31:0] o_addr [N];
  logic [31:0] o_gray [N];
  logic [31:0] o_lvl [N];
  logic [31:0] o_full [N];
  logic [31:0] o_empty [N];
  logic [31:0] o_afull [N];
  logic [31:0] o_aempty [N];
  logic [31:0] o_err [N];

  function automatic int md(int x, int p);
    return ((x % p) + p) % p;
  endfunction

  function automatic int gray_of(int b, int aw);
    int m;
    m = md(b, 1 << (aw + 1));
    return m ^ (m >> 1);
  endfunction

  assign if0.inc_req  = req[0];
  assign if1.inc_req  = req[1];
  assign if2.inc_req  = req[2];
  assign if0.rmt_gray = 4'(gray_of(rbin[0], 3));
  assign if1.rmt_gray = 4'(gray_of(rbin[1], 3));
  assign if2.rmt_gray = 5'(gray_of(rbin[2], 4));

  assign o_ack[0] = 32'(if0.inc_ack);   assign o_ack[1] = 32'(if1.inc_ack);   assign o_ack[2] = 32'(if2.inc_ack);
  assign o_addr[0] = 32'(if0.loc_addr); assign o_addr[1] = 32'(if1.loc_addr); assign o_addr[2] = 32'(if2.loc_addr);
  assign o_gray[0] = 32'(if0.loc_gray); assign o_gray[1] = 32'(if1.loc_gray); assign o_gray[2] = 32'(if2.loc_gray);
  assign o_lvl[0] = 32'(if0.level);     assign o_lvl[1] = 32'(if1.level);     assign o_lvl[2] = 32'(if2.level);
  assign o_full[0] = 32'(if0.full);     assign o_full[1] = 32'(if1.full);     assign o_full[2] = 32'(if2.full);
  assign o_empty[0] = 32'(if0.empty);   assign o_empty[1] = 32'(if1.empty);   assign o_empty[2] = 32'(if2.empty);
  assign o_afull[0] = 32'(if0.afull);   assign o_afull[1] = 32'(if1.afull);   assign o_afull[2] = 32'(if2.afull);
  assign o_aempty[0] = 32'(if0.aempty); assign o_aempty[1] = 32'(if1.aempty); assign o_aempty[2] = 32'(if2.aempty);
  assign o_err[0] = 32'(if0.ptr_err);   assign o_err[1] = 32'(if1.ptr_err);   assign o_err[2] = 32'(if2.ptr_err);

  task automatic chk(string tag, int k, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_loc[k] = 0; m_lvl[k] = 0; m_full[k] = 0; m_empty[k] = 1;
      m_afull[k] = 0; m_aempty[k] = 1; m_err[k] = 0; n_ack[k] = 0;
    end
    ncyc = 0;
  endtask

  // Remote value seen by the level math is the one driven PIPE cycles ago (0 before that).
  task automatic model_upd(int k, int ack);
    int p, d, r, l;
    p = 1 << (c_aw[k] + 1);
    d = 1 << c_aw[k];
    rh[k][ncyc % HL] = rbin[k];
    r = (ncyc >= c_pipe[k]) ? rh[k][(ncyc - c_pipe[k]) % HL] : 0;
    m_loc[k] = md(m_loc[k] + ack, p);
    l = (c_mode[k] == 0) ? md(m_loc[k] - r, p) : md(r - m_loc[k], p);
    if (l > d) m_err[k] = 1;
    m_lvl[k]    = l;
    m_full[k]   = (l == d || (c_mode[k] == 0 && m_err[k] == 1)) ? 1 : 0;
    m_empty[k]  = (l == 0 || (c_mode[k] == 1 && m_err[k] == 1)) ? 1 : 0;
    m_afull[k]  = (l >= c_afth[k]) ? 1 : 0;
    m_aempty[k] = (l <= c_aeth[k]) ? 1 : 0;
  endtask

  task automatic tick();
    int a [N];
    logic [31:0] pg [N];
    #1;
    for (int k = 0; k < N; k++) begin
      a[k] = (!rst && req[k] && ((c_mode[k] == 0) ? m_full[k] == 0 : m_empty[k] == 0)) ? 1 : 0;
      chk("inc_ack", k, o_ack[k], 32'(a[k]));
      n_ack[k] += (o_ack[k] === 32'd1) ? 1 : 0;
      pg[k] = o_gray[k];
    end
    @(posedge clk_sys);
    if (rst) model_reset();
    else begin
      for (int k = 0; k < N; k++) model_upd(k, a[k]);
      ncyc++;
    end
    @(negedge clk_sys);
    for (int k = 0; k < N; k++) begin
      chk("loc_addr", k, o_addr[k], 32'(m_loc[k] % (1 << c_aw[k])));
      chk("loc_gray", k, o_gray[k], 32'(gray_of(m_loc[k], c_aw[k])));
      chk("level", k, o_lvl[k], 32'(m_lvl[k]));
      chk("full", k, o_full[k], 32'(m_full[k]));
      chk("empty", k, o_empty[k], 32'(m_empty[k]));
      chk("afull", k, o_afull[k], 32'(m_afull[k]));
      chk("aempty", k, o_aempty[k], 32'(m_aempty[k]));
      chk("ptr_err", k, o_err[k], 32'(m_err[k]));
      if (a[k] == 1 && !rst) chk("gray_step", k, 32'($countones(o_gray[k] ^ pg[k])), 32'd1);
    end
  endtask

  task automatic idle_all();
    for (int k = 0; k < N; k++) req[k] = 1'b0;
  endtask

  task automatic do_reset();
    idle_all();
    for (int k = 0; k < N; k++) rbin[k] = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    c_aw   = '{3, 3, 4};
    c_mode = '{0, 1, 0};
    c_pipe = '{0, 2, 1};
    c_afth = '{6, 6, 14};
    c_aeth = '{1, 1, 1};
    model_reset();
    idle_all();
    for (int k = 0; k < N; k++) rbin[k] = 0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_level", 0, o_lvl[0], 32'd0);
    chk("rst_empty", 0, o_empty[0], 32'd1);
    chk("rst_aempty", 1, o_aempty[1], 32'd1);
    chk("rst_gray", 2, o_gray[2], 32'd0);

    // Fill write side: eight acks, then full blocks the ninth request.
    req[0] = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    req[0] = 1'b0;
    chk("fill_acks", 0, 32'(n_ack[0]), 32'd8);
    chk("fill_level", 0, o_lvl[0], 32'd8);
    chk("fill_full", 0, o_full[0], 32'd1);
    chk("fill_afull", 0, o_afull[0], 32'd1);

    // Remote advance and local push in one cycle keep level steady.
    rbin[0] = 3;
    tick();
    chk("simul_pre", 0, o_lvl[0], 32'd5);
    req[0] = 1'b1; rbin[0] = 4;
    tick();
    req[0] = 1'b0;
    chk("simul_post", 0, o_lvl[0], 32'd5);

    // Read side with a two-stage decode pipe.
    rbin[1] = 1; tick();
    rbin[1] = 2; tick();
    chk("drain_lag", 1, o_lvl[1], 32'd0);
    tick(); tick();
    chk("drain_level", 1, o_lvl[1], 32'd2);
    chk("drain_empty", 1, o_empty[1], 32'd0);
    req[1] = 1'b1;
    tick(); tick(); tick();
    req[1] = 1'b0;
    chk("drain_acks", 1, 32'(n_ack[1]), 32'd2);
    chk("drain_level0", 1, o_lvl[1], 32'd0);
    chk("drain_empty1", 1, o_empty[1], 32'd1);

    // Wrap on the AW=4 instance: loc 15 -> 16 -> ... -> 31 -> 0.
    for (int i = 0; i < 15; i++) begin
      req[2] = 1'b1;
      rbin[2] = (i == 0) ? 0 : i - 1;
      tick();
    end
    req[2] = 1'b0; rbin[2] = 14;
    tick(); tick(); tick();
    chk("wrap_lvl1", 2, o_lvl[2], 32'd1);
    chk("wrap_gray15", 2, o_gray[2], 32'h08);
    req[2] = 1'b1;
    tick();
    req[2] = 1'b0;
    chk("wrap_gray16", 2, o_gray[2], 32'h18);
    chk("wrap_lvl2", 2, o_lvl[2], 32'd2);
    for (int i = 0; i < 20; i++) begin
      req[2] = 1'b1;
      rbin[2] = n_ack[2] - 1;
      tick();
    end
    req[2] = 1'b0;
    chk("wrap_acks", 2, 32'(n_ack[2]), 32'd36);

    // Impossible remote pointer: level 9 on an 8-deep FIFO latches ptr_err.
    do_reset();
    rbin[0] = 23;
    tick();
    chk("err_level", 0, o_lvl[0], 32'd9);
    chk("err_flag", 0, o_err[0], 32'd1);
    chk("err_full", 0, o_full[0], 32'd1);
    rbin[0] = 0;
    tick(); tick();
    req[0] = 1'b1;
    tick();
    req[0] = 1'b0;
    chk("err_sticky", 0, o_err[0], 32'd1);
    chk("err_fullhold", 0, o_full[0], 32'd1);
    do_reset();
    chk("err_cleared", 0, o_err[0], 32'd0);

    // Reset mid-fill with the request still asserted.
    req[0] = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("mid_level5", 0, o_lvl[0], 32'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req[0] = 1'b0;
    chk("mid_level0", 0, o_lvl[0], 32'd0);
    chk("mid_empty", 0, o_empty[0], 32'd1);
    chk("mid_gray", 0, o_gray[0], 32'd0);

    // Random traffic: push-heavy half then drain-heavy half, remote side kept legal.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      int hi;
      hi = (c < 400) ? 1 : 0;
      for (int k = 0; k < N; k++) begin
        if (c_mode[k] == 0) begin
          req[k] = (hi == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
          if (rbin[k] < n_ack[k] && $urandom_range(0, 3) < ((hi == 1) ? 1 : 3)) rbin[k]++;
        end else begin
          req[k] = (hi == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
          if (rbin[k] - n_ack[k] < (1 << c_aw[k]) && $urandom_range(0, 3) < ((hi == 1) ? 3 : 1)) rbin[k]++;
        end
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
